// File: rtl/pic_decoder_pkg.sv
// Shared types and constants for the picture read-back decoder.
// The scan-order mapping lives here so the top and any checker agree on it.
package pic_decoder_pkg;

  localparam int PIX_W      = 24;
  localparam int ADDR_W     = 18;
  localparam int CODE_W     = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 12;
  localparam int NPIX       = 4096;
  localparam int IMG_W      = 64;
  localparam int COL_B      = $clog2(IMG_W);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RASTER     = 2'd0,
    REV_RASTER = 2'd1,
    COL_MAJOR  = 2'd2,
    ROW_REV    = 2'd3
  } scan_mode_t;

  function automatic logic [IDX_W-1:0] scan_addr(input scan_mode_t mode,
                                                 input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] p;
    case (mode)
      RASTER:     p = k;
      REV_RASTER: p = ~k;  // 4095 - k for a 12-bit index
      COL_MAJOR:  p = {k[COL_B-1:0], k[IDX_W-1:COL_B]};
      ROW_REV:    p = {k[IDX_W-1:COL_B], ~k[COL_B-1:0]};
      default:    p = k;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pic_decoder_if.sv
// Bus bundle between the decoder, its two synchronous-read RAMs and the pixel sink.
interface pic_decoder_if;
  import pic_decoder_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic              RAM_PIC_OE;
  logic [ADDR_W-1:0] RAM_PIC_A;
  logic [PIX_W-1:0]  RAM_PIC_Q;
  logic              RAM_W_OE;
  logic [ADDR_W-1:0] RAM_W_A;
  logic [PIX_W-1:0]  RAM_W_Q;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pixel;
  logic [IDX_W-1:0]  out_index;
  logic              busy;
  logic              done;

  modport master (
    input  start, mode, RAM_PIC_Q, RAM_W_Q, out_ready,
    output RAM_PIC_OE, RAM_PIC_A, RAM_W_OE, RAM_W_A,
           out_valid, out_pixel, out_index, busy, done
  );

  modport slave (
    output start, mode, RAM_PIC_Q, RAM_W_Q, out_ready,
    input  RAM_PIC_OE, RAM_PIC_A, RAM_W_OE, RAM_W_A,
           out_valid, out_pixel, out_index, busy, done
  );

endinterface

// File: rtl/pic_decoder_pix_fifo.sv
// Small synchronous output FIFO; the head entry is visible combinationally.
// Push is accepted when full only if a pop happens in the same cycle.
module pix_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 36,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pic_decoder.sv
// Walks the tag picture in the chosen scan order, looks up each codeword and
// streams the RGB result. Issue is credit-limited so the FIFO never overflows.
//   state | meaning
//   IDLE  | waiting for start, mode latched on accept
//   RUN   | issuing one tag read per cycle while credit allows
//   DRAIN | all reads issued, waiting for pipeline and FIFO to empty
//   DONE  | one-cycle done pulse
module pic_decoder
  import pic_decoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  pic_decoder_if.master bus
);

  localparam int OCC_W = CNT_W + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  scan_mode_t              r_mode;
  logic [IDX_W-1:0]        r_k;
  logic                    r_v_pic;
  logic [IDX_W-1:0]        r_p_pic;
  logic                    r_v_w;
  logic [IDX_W-1:0]        r_p_w;
  logic [IDX_W-1:0]        w_p;
  logic                    w_issue;
  logic                    w_credit;
  logic                    w_pop;
  logic                    w_drained;
  logic [OCC_W-1:0]        w_occ;
  logic [CNT_W-1:0]        w_fifo_cnt;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [PIX_W+IDX_W-1:0]  w_head;
  logic                    w_unused;

  assign w_p   = scan_addr(r_mode, r_k);
  assign w_pop = !w_fifo_empty && bus.out_ready;

  // Everything already committed (FIFO plus both pipeline slots) minus what leaves now
  assign w_occ = OCC_W'(w_fifo_cnt) + OCC_W'(r_v_pic) + OCC_W'(r_v_w) - OCC_W'(w_pop);
  assign w_credit = (w_occ < OCC_W'(FIFO_DEPTH));

  // Finish on the edge of the last handshake so done lands the cycle after it
  assign w_drained = !r_v_pic && !r_v_w &&
                     (w_fifo_empty || ((w_fifo_cnt == CNT_W'(1)) && w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_state_nxt = RUN;
      RUN: begin
        w_issue = w_credit;
        if (w_credit && (r_k == IDX_W'(NPIX - 1))) w_state_nxt = DRAIN;
      end
      DRAIN: if (w_drained) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= RASTER;
      r_k     <= '0;
      r_v_pic <= 1'b0;
      r_p_pic <= '0;
      r_v_w   <= 1'b0;
      r_p_w   <= '0;
    end else begin
      if ((r_state == IDLE) && bus.start) begin
        r_mode <= scan_mode_t'(bus.mode);
        r_k    <= '0;
      end else if (w_issue) begin
        r_k <= r_k + IDX_W'(1);
      end
      r_v_pic <= w_issue;
      r_p_pic <= w_p;
      r_v_w   <= r_v_pic;
      r_p_w   <= r_p_pic;
    end
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W + IDX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_v_w),
    .i_data  ({bus.RAM_W_Q, r_p_w}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.RAM_PIC_OE = w_issue;
  assign bus.RAM_PIC_A  = w_issue ? ADDR_W'(w_p) : '0;
  assign bus.RAM_W_OE   = r_v_pic;
  assign bus.RAM_W_A    = r_v_pic ? ADDR_W'(bus.RAM_PIC_Q[CODE_W-1:0]) : '0;
  assign bus.out_valid  = !w_fifo_empty;
  assign {bus.out_pixel, bus.out_index} = w_head;
  assign bus.busy       = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done       = (r_state == DONE);

  // Upper tag bits carry no code; full flag is implied by the credit rule
  assign w_unused = ^{bus.RAM_PIC_Q[PIX_W-1:CODE_W], w_fifo_full};

endmodule

// File: tb/tb_pic_decoder.sv
// Randomized bench for pic_decoder: RAM models, a scan/latency/credit reference
// model checked every cycle, and literal probes on latency, addresses and timing.
module tb_pic_decoder;
  import pic_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pic_decoder_if bus ();

  pic_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] pic_mem [NPIX];
  logic [PIX_W-1:0] w_mem   [64];
  logic [PIX_W-1:0] pic_q = '0;
  logic [PIX_W-1:0] w_q   = '0;

  assign bus.RAM_PIC_Q = pic_q;
  assign bus.RAM_W_Q   = w_q;

  always @(posedge clk) begin
    if (bus.RAM_PIC_OE) pic_q <= pic_mem[bus.RAM_PIC_A[11:0]];
    if (bus.RAM_W_OE)   w_q   <= w_mem[bus.RAM_W_A[5:0]];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tb_scan(input int m, input int k);
    case (m)
      0:       return k;
      1:       return NPIX - 1 - k;
      2:       return (k % IMG_W) * IMG_W + k / IMG_W;
      default: return (k / IMG_W) * IMG_W + (IMG_W - 1 - k % IMG_W);
    endcase
  endfunction

  // Reference model state
  bit               m_active = 0;
  int               n_iss = 0;
  int               n_acc = 0;
  int               cyc = 0;
  bit               prev_oe = 0;
  int               prev_p = 0;
  int               exp_p   [NPIX];
  logic [PIX_W-1:0] exp_pix [NPIX];
  int               iss_cyc [NPIX];
  bit               seen    [NPIX];
  bit               ev, eo, pop, fin, was_active;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs_zero",
          32'({bus.RAM_PIC_OE, bus.RAM_W_OE, bus.out_valid, bus.busy, bus.done,
               |bus.RAM_PIC_A, |bus.RAM_W_A, |bus.out_pixel, |bus.out_index}), 32'd0);
      m_active = 0;
      n_iss    = 0;
      n_acc    = 0;
      prev_oe  = 0;
    end else begin
      ev  = m_active && (n_acc < n_iss) && (iss_cyc[n_acc] + 3 <= cyc);
      pop = ev && bus.out_ready;
      eo  = m_active && (n_iss < NPIX) && ((n_iss - n_acc - int'(pop)) < FIFO_DEPTH);
      fin = m_active && (n_acc == NPIX);
      chk("busy", 32'(bus.busy), 32'(m_active && (n_acc < NPIX)));
      chk("done", 32'(bus.done), 32'(fin));
      chk("pic_oe", 32'(bus.RAM_PIC_OE), 32'(eo));
      if (eo) chk("pic_addr", 32'(bus.RAM_PIC_A), 32'(exp_p[n_iss]));
      chk("w_oe", 32'(bus.RAM_W_OE), 32'(prev_oe));
      if (prev_oe) chk("w_addr", 32'(bus.RAM_W_A), 32'(pic_mem[prev_p] % 64));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) begin
        chk("out_index", 32'(bus.out_index), 32'(exp_p[n_acc]));
        chk("out_pixel", 32'(bus.out_pixel), 32'(exp_pix[n_acc]));
      end
      was_active = m_active;
      prev_oe    = eo;
      if (eo) begin
        prev_p         = exp_p[n_iss];
        iss_cyc[n_iss] = cyc;
        n_iss++;
      end
      if (pop) begin
        seen[bus.out_index] = 1;
        n_acc++;
      end
      if (fin) m_active = 0;
      else if (!was_active && bus.start) begin
        m_active = 1;
        n_iss    = 0;
        n_acc    = 0;
        for (int k = 0; k < NPIX; k++) begin
          exp_p[k]   = tb_scan(int'(bus.mode), k);
          exp_pix[k] = w_mem[pic_mem[exp_p[k]] % 64];
          seen[k]    = 0;
        end
      end
    end
    cyc++;
  end

  task automatic do_run(input int m, input int pat, input int abort_at,
                        input int first_idx, input int first_pix, input int first_wa);
    int n;
    int low;
    int cnt;
    bit hs;
    n = 0; low = 0; hs = 0; cnt = 0;
    @(posedge clk); #1;
    bus.mode      = 2'(m);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 20000) begin
      if (n == 1) begin
        chk("first_w_oe", 32'(bus.RAM_W_OE), 32'd1);
        chk("first_w_addr", 32'(bus.RAM_W_A), 32'(first_wa));
      end
      if (n == 2) chk("valid_not_before_3", 32'(bus.out_valid), 32'd0);
      if (n == 3) begin
        chk("first_valid_latency3", 32'(bus.out_valid), 32'd1);
        chk("first_index", 32'(bus.out_index), 32'(first_idx));
        chk("first_pixel", 32'(bus.out_pixel), 32'(first_pix));
      end
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero",
            32'({bus.RAM_PIC_OE, bus.RAM_W_OE, bus.out_valid, bus.busy, bus.done,
                 |bus.RAM_PIC_A, |bus.RAM_W_A, |bus.out_pixel, |bus.out_index}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      case (pat)
        0: bus.out_ready = 1'b1;
        1: begin
          if (!hs) bus.out_ready = 1'b1;
          else if (low < 10) begin
            bus.out_ready = 1'b0;
            low++;
            if (low == 10) chk("stalled_no_issue", 32'(bus.RAM_PIC_OE), 32'd0);
          end else bus.out_ready = ~bus.out_ready;
          if (bus.out_ready && bus.out_valid) hs = 1;
          bus.start = (n == 50);
        end
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    chk("run_finished_in_budget", 32'(n < 20000), 32'd1);
    if (pat == 0) chk("done_cycle_after_start", 32'(n), 32'd4099);
    for (int i = 0; i < NPIX; i++) cnt += int'(seen[i]);
    chk("all_indices_delivered", 32'(cnt), 32'(NPIX));
  endtask

  int md, fi;

  initial begin
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;

    // All codes 5, W[5] = 0xABCDEF, raster, sink always ready
    for (int p = 0; p < NPIX; p++) pic_mem[p] = {18'($urandom), 6'd5};
    for (int i = 0; i < 64; i++) w_mem[i] = 24'($urandom);
    w_mem[5] = 24'hABCDEF;
    do_run(0, 0, -1, 0, 32'hABCDEF, 5);

    // Column-major with identity codebook
    for (int p = 0; p < NPIX; p++) pic_mem[p] = {18'($urandom), 6'(p % 64)};
    for (int i = 0; i < 64; i++) w_mem[i] = 24'(i);
    do_run(2, 0, -1, 0, 0, 0);

    // Backpressure, dirty upper tag bits, ignored start during RUN
    for (int p = 0; p < NPIX; p++) pic_mem[p] = 24'($urandom);
    for (int i = 0; i < 64; i++) w_mem[i] = 24'($urandom);
    pic_mem[0] = 24'hFFFFC3;
    do_run(0, 1, -1, 0, int'(w_mem[3]), 3);

    // Abort around k=1000
    md = int'($urandom_range(0, 3));
    fi = tb_scan(md, 0);
    do_run(md, 0, 1000, fi, int'(w_mem[pic_mem[fi] % 64]), int'(pic_mem[fi] % 64));

    // Reverse raster and right-to-left rows under random backpressure
    for (int p = 0; p < NPIX; p++) pic_mem[p] = {18'($urandom), 6'(p % 64)};
    for (int i = 0; i < 64; i++) w_mem[i] = 24'($urandom);
    do_run(1, 2, -1, 4095, int'(w_mem[63]), 63);
    do_run(3, 2, -1, 63, int'(w_mem[63]), 63);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pic_decoder.md
# pic_decoder

Read-back engine for the quantized-image path. It walks the 64×64 tag picture memory (RAM_PIC) in a selectable scan order and uses each stored 6-bit codeword index to look up the 24-bit codeword in the weight memory (RAM_W). The reconstructed RGB pixels leave on a valid/ready stream. It sits downstream of the training/labelling controller and decodes what that controller wrote.

## Interface
- PIX_W, 24, pixel/codeword width
- ADDR_W, 18, RAM address width
- CODE_W, 6, codeword index width (64 codewords)
- FIFO_DEPTH, 4, output buffer depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one full-image decode; sampled only in IDLE
- mode  in  2  scan order, latched at start
- RAM_PIC_OE  out  1  tag memory read enable
- RAM_PIC_A  out  ADDR_W  tag memory address
- RAM_PIC_Q  in  PIX_W  tag memory read data; code is in [CODE_W-1:0]
- RAM_W_OE  out  1  weight memory read enable
- RAM_W_A  out  ADDR_W  weight memory address
- RAM_W_Q  in  PIX_W  weight memory read data
- out_valid  out  1  out_pixel/out_index valid
- out_ready  in  1  sink accepts the current beat
- out_pixel  out  PIX_W  decoded RGB
- out_index  out  12  raster address of the pixel
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1. In the same edge, latch mode and clear the scan counter k (12 bits).
  - RUN: issue one RAM_PIC read per cycle while credit is available. After issuing k=4095, go to DRAIN.
  - DRAIN: wait until both pipeline stages and the FIFO are empty, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
  - start outside IDLE is ignored.
- Scan order for index k (pixel address p):
  - mode 0: p = k (raster)
  - mode 1: p = 4095−k (reverse raster)
  - mode 2: p = {k[5:0], k[11:6]} (column-major)
  - mode 3: p = {k[11:6], ~k[5:0]} (rows right-to-left)
- Address formation:
  - RAM_PIC_A = zero-extended p.
  - RAM_W_A = zero-extended RAM_PIC_Q[CODE_W-1:0]. Upper bits of RAM_PIC_Q are ignored.
- Pipeline: stage 1 issues the PIC read. Stage 2 receives the code and issues the W read. Stage 3 writes {RAM_W_Q, p} into the FIFO. Each stage carries a valid bit and p.
- Credit rule: issue only if (FIFO occupancy + in-flight stages − pop this cycle) < FIFO_DEPTH. The FIFO never overflows and no beat is dropped.
- RAM_W_OE is high exactly when stage 2 holds a valid entry.
- Stream rules:
  - out_pixel/out_index are held stable while out_valid=1 and out_ready=0.
  - A beat transfers on out_valid&out_ready.
  - Exactly 4096 beats per start.

## Timing
- Both RAMs are synchronous-read: data is valid in the cycle after OE/address are presented.
- Start sampled at edge E0:
  - first RAM_PIC_OE in cycle E0–E1
  - RAM_W_OE in cycle E1–E2
  - FIFO write at E3
  - first out_valid after E3 (latency 3)
- Throughput is 1 beat/cycle with out_ready held high. A full image takes 4096+3 cycles plus the DONE cycle.
- done pulses in the cycle after the 4096th handshake. busy drops in the same cycle.
- Reset values: all outputs 0, FSM IDLE, FIFO empty, counters 0.
- Reset mid-operation aborts immediately. No done pulse is generated, and the in-flight data is discarded.
- out_ready low for any duration: RAM_PIC_OE stops once credit is exhausted. At most FIFO_DEPTH beats are buffered, and issue resumes the cycle after a pop frees credit.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - scan mode constants (RASTER, REV_RASTER, COL_MAJOR, ROW_REV)
  - NPIX=4096 and IMG_W=64
- Sub-module pix_fifo: synchronous FIFO, FIFO_DEPTH×(PIX_W+12), with push, pop, occupancy count, full, empty.
  - Simultaneous push/pop when full or when empty must be legal.
  - Its head drives out_pixel/out_index.
- The top contains the FSM, scan counter, address mapping, pipeline valids and credit logic.

## Test plan
- Mode 0, out_ready=1, all PIC codes 5, W[5]=0xABCDEF -> 4096 beats of 0xABCDEF with out_index 0..4095; first out_valid 3 cycles after start; done 1 cycle after the last beat.
- Mode 2, PIC[p]=p[5:0], W[i]=i -> out_index sequence 0,64,128,…,4032,1,65,…; out_pixel equals out_index[5:0].
- Backpressure: out_ready low for 10 cycles after the first beat, then toggling every cycle -> ≤4 beats buffered, RAM_PIC_OE low when credit is exhausted, every p delivered exactly once in order.
- RAM_PIC_Q=0xFFFFC3 -> RAM_W_A=3; start pulsed during RUN -> ignored, still exactly 4096 beats.
- rst asserted at k≈1000 -> all outputs 0 immediately and no done pulse; a new start decodes the full image from k=0.
- Modes 1 and 3 with PIC[p]=p[5:0] -> first out_index 4095 for mode 1 and 63 for mode 3; all 4096 indices covered.
